// File: rtl/rs_param_oldest_first.sv
// rtl/rs_param_oldest_first.sv - parametrised reservation station, oldest-ready-first issue
// Entries snoop the CDB for operand wakeup; an age matrix picks the oldest ready entry.
module rs_param_oldest_first #(
  parameter int DEPTH   = 4,
  parameter int NUM_CDB = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4,
  parameter int IMM_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [TAG_W-1:0]            in_rob_idx,
  input  logic [OP_W-1:0]             in_opcode,
  input  logic [IMM_W-1:0]            in_imm,
  input  logic                        in_a_valid,
  input  logic [DATA_W-1:0]           in_a_value,
  input  logic [TAG_W-1:0]            in_a_owner,
  input  logic                        in_b_valid,
  input  logic [DATA_W-1:0]           in_b_value,
  input  logic [TAG_W-1:0]            in_b_owner,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_W-1:0]            out_rob_idx,
  output logic [OP_W-1:0]             out_opcode,
  output logic [IMM_W-1:0]            out_imm,
  output logic [DATA_W-1:0]           out_a,
  output logic [DATA_W-1:0]           out_b
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d, a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic [TAG_W-1:0]  rob_q [DEPTH], rob_d [DEPTH];
  logic [OP_W-1:0]   op_q [DEPTH], op_d [DEPTH];
  logic [IMM_W-1:0]  imm_q [DEPTH], imm_d [DEPTH];
  logic [DATA_W-1:0] a_val_q [DEPTH], a_val_d [DEPTH], b_val_q [DEPTH], b_val_d [DEPTH];
  logic [TAG_W-1:0]  a_tag_q [DEPTH], a_tag_d [DEPTH], b_tag_q [DEPTH], b_tag_d [DEPTH];
  logic [DEPTH-1:0]  age_q [DEPTH], age_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic              out_valid_q, out_valid_d;
  logic [TAG_W-1:0]  out_rob_q, out_rob_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [IMM_W-1:0]  out_imm_q, out_imm_d;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;

  logic [DEPTH-1:0]  ready, sel_oh;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              issue_en, issue_fire, alloc;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                   input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (v[k] && tags[k*TAG_W +: TAG_W] == tag) cdb_hit = 1'b1;
  endfunction

  // Scan high-to-low so the lowest matching port is the one that sticks.
  function automatic logic [DATA_W-1:0] cdb_data(input logic [TAG_W-1:0] tag,
                                                 input logic [NUM_CDB-1:0] v,
                                                 input logic [NUM_CDB*TAG_W-1:0] tags,
                                                 input logic [NUM_CDB*DATA_W-1:0] vals);
    cdb_data = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (v[k] && tags[k*TAG_W +: TAG_W] == tag) cdb_data = vals[k*DATA_W +: DATA_W];
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  assign issue_en   = !out_valid_q || out_ready;
  assign issue_fire = issue_en && (|ready);
  assign alloc      = in_valid && !full && !flush;

  always_comb begin
    ready  = valid_q & a_rdy_q & b_rdy_q;
    sel_oh = ready;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && age_q[j][i]) sel_oh[i] = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    valid_d = valid_q;
    a_rdy_d = a_rdy_q;
    b_rdy_d = b_rdy_q;
    rob_d   = rob_q;
    op_d    = op_q;
    imm_d   = imm_q;
    a_val_d = a_val_q;
    b_val_d = b_val_q;
    a_tag_d = a_tag_q;
    b_tag_d = b_tag_q;
    age_d   = age_q;
    count_d = count_q + CNT_W'(alloc) - CNT_W'(issue_fire);
    out_valid_d = out_valid_q;
    out_rob_d   = out_rob_q;
    out_op_d    = out_op_q;
    out_imm_d   = out_imm_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (!a_rdy_q[i] && cdb_hit(a_tag_q[i], cdb_valid, cdb_tag)) begin
        a_rdy_d[i] = 1'b1;
        a_val_d[i] = cdb_data(a_tag_q[i], cdb_valid, cdb_tag, cdb_value);
      end
      if (!b_rdy_q[i] && cdb_hit(b_tag_q[i], cdb_valid, cdb_tag)) begin
        b_rdy_d[i] = 1'b1;
        b_val_d[i] = cdb_data(b_tag_q[i], cdb_valid, cdb_tag, cdb_value);
      end
    end

    if (issue_en) begin
      out_valid_d = |ready;
      if (|ready) begin
        out_rob_d        = rob_q[sel_idx];
        out_op_d         = op_q[sel_idx];
        out_imm_d        = imm_q[sel_idx];
        out_a_d          = a_val_q[sel_idx];
        out_b_d          = b_val_q[sel_idx];
        valid_d[sel_idx] = 1'b0;
      end
    end

    if (alloc) begin
      valid_d[free_idx] = 1'b1;
      rob_d[free_idx]   = in_rob_idx;
      op_d[free_idx]    = in_opcode;
      imm_d[free_idx]   = in_imm;
      a_tag_d[free_idx] = in_a_owner;
      b_tag_d[free_idx] = in_b_owner;
      a_rdy_d[free_idx] = in_a_valid || cdb_hit(in_a_owner, cdb_valid, cdb_tag);
      a_val_d[free_idx] = in_a_valid ? in_a_value
                                     : cdb_data(in_a_owner, cdb_valid, cdb_tag, cdb_value);
      b_rdy_d[free_idx] = in_b_valid || cdb_hit(in_b_owner, cdb_valid, cdb_tag);
      b_val_d[free_idx] = in_b_valid ? in_b_value
                                     : cdb_data(in_b_owner, cdb_valid, cdb_tag, cdb_value);
      // New entry is younger than every entry already resident.
      age_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = valid_q[j];
    end

    if (flush) begin
      valid_d     = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      a_rdy_q <= '0;
      b_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i]   <= '0;
        op_q[i]    <= '0;
        imm_q[i]   <= '0;
        a_val_q[i] <= '0;
        b_val_q[i] <= '0;
        a_tag_q[i] <= '0;
        b_tag_q[i] <= '0;
        age_q[i]   <= '0;
      end
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_rob_q   <= '0;
      out_op_q    <= '0;
      out_imm_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      a_rdy_q     <= a_rdy_d;
      b_rdy_q     <= b_rdy_d;
      rob_q       <= rob_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      a_val_q     <= a_val_d;
      b_val_q     <= b_val_d;
      a_tag_q     <= a_tag_d;
      b_tag_q     <= b_tag_d;
      age_q       <= age_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_rob_q   <= out_rob_d;
      out_op_q    <= out_op_d;
      out_imm_q   <= out_imm_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign count       = count_q;
  assign out_valid   = out_valid_q;
  assign out_rob_idx = out_rob_q;
  assign out_opcode  = out_op_q;
  assign out_imm     = out_imm_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;

endmodule

// File: tb/tb_rs_param_oldest_first.sv
// tb/tb_rs_param_oldest_first.sv - scoreboard bench for rs_param_oldest_first
// Reference model keeps waiting instructions in an age-ordered queue.
module tb_rs_param_oldest_first;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid;
  logic [3:0]  in_rob_idx, in_opcode;
  logic [7:0]  in_imm;
  logic        in_a_valid, in_b_valid;
  logic [15:0] in_a_value, in_b_value;
  logic [3:0]  in_a_owner, in_b_owner;
  logic        full;
  logic [2:0]  count;
  logic [3:0]  cdb_valid;
  logic [15:0] cdb_tag;
  logic [63:0] cdb_value;
  logic        out_valid, out_ready;
  logic [3:0]  out_rob_idx, out_opcode;
  logic [7:0]  out_imm;
  logic [15:0] out_a, out_b;

  always #5 clk = ~clk;

  rs_param_oldest_first dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_rob_idx(in_rob_idx), .in_opcode(in_opcode), .in_imm(in_imm),
    .in_a_valid(in_a_valid), .in_a_value(in_a_value), .in_a_owner(in_a_owner),
    .in_b_valid(in_b_valid), .in_b_value(in_b_value), .in_b_owner(in_b_owner),
    .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_idx(out_rob_idx), .out_opcode(out_opcode), .out_imm(out_imm),
    .out_a(out_a), .out_b(out_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [3:0]  rob, op;
    logic [7:0]  imm;
    bit          ar, br;
    logic [15:0] av, bv;
    logic [3:0]  at, bt;
  } ent_t;

  ent_t        ent_q[$];
  logic [47:0] exp_q[$];
  bit          m_ov;
  int          pre_n, sel;
  ent_t        e;
  logic [15:0] v;

  function automatic bit cdb_look(input logic [3:0] tag, output logic [15:0] val);
    for (int k = 0; k < 4; k++)
      if (cdb_valid[k] && cdb_tag[k*4 +: 4] == tag) begin
        val = cdb_value[k*16 +: 16];
        return 1'b1;
      end
    val = '0;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      ent_q.delete();
      exp_q.delete();
      m_ov = 1'b0;
    end else begin
      pre_n = ent_q.size();
      if (!m_ov || out_ready) begin
        sel = -1;
        foreach (ent_q[i]) if (sel < 0 && ent_q[i].ar && ent_q[i].br) sel = i;
        if (sel >= 0) begin
          e = ent_q[sel];
          exp_q.push_back({e.rob, e.op, e.imm, e.av, e.bv});
          ent_q.delete(sel);
          m_ov = 1'b1;
        end else m_ov = 1'b0;
      end
      foreach (ent_q[i]) begin
        if (!ent_q[i].ar && cdb_look(ent_q[i].at, v)) begin ent_q[i].ar = 1'b1; ent_q[i].av = v; end
        if (!ent_q[i].br && cdb_look(ent_q[i].bt, v)) begin ent_q[i].br = 1'b1; ent_q[i].bv = v; end
      end
      if (in_valid && pre_n < DEPTH) begin
        e.rob = in_rob_idx; e.op = in_opcode; e.imm = in_imm;
        e.ar = in_a_valid; e.av = in_a_value; e.at = in_a_owner;
        e.br = in_b_valid; e.bv = in_b_value; e.bt = in_b_owner;
        if (!in_a_valid && cdb_look(in_a_owner, v)) begin e.ar = 1'b1; e.av = v; end
        if (!in_b_valid && cdb_look(in_b_owner, v)) begin e.br = 1'b1; e.bv = v; end
        ent_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(count), 64'(ent_q.size()));
      chk("full", 64'(full), 64'(ent_q.size() == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov && exp_q.size() > 0) begin
        chk("issue", {16'h0, out_rob_idx, out_opcode, out_imm, out_a, out_b}, {16'h0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; flush = 1'b0; cdb_valid = '0;
  endtask

  task automatic dispatch(input logic [3:0] rob, input bit av_ok, input logic [15:0] av,
                          input logic [3:0] at, input bit bv_ok, input logic [15:0] bv);
    in_valid = 1'b1; in_rob_idx = rob; in_opcode = rob ^ 4'h5; in_imm = {rob, 4'hA};
    in_a_valid = av_ok; in_a_value = av; in_a_owner = at;
    in_b_valid = bv_ok; in_b_value = bv; in_b_owner = 4'hF;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rob_idx = '0; in_opcode = '0; in_imm = '0;
    in_a_valid = 1'b0; in_a_value = '0; in_a_owner = '0; in_b_valid = 1'b0; in_b_value = '0;
    in_b_owner = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_out_a", 64'(out_a), 0);
    rst_n = 1'b1;
    step();

    // ready dispatch
    dispatch(4'd1, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7);
    step(); idle_in(); step();
    chk("rd_valid", 64'(out_valid), 1);
    chk("rd_a", 64'(out_a), 5);
    chk("rd_b", 64'(out_b), 7);
    chk("rd_count", 64'(count), 0);
    step();

    // wakeup via CDB port 2, then dispatch-cycle bypass on port 0
    dispatch(4'd2, 1'b0, 16'h0, 4'd3, 1'b1, 16'h0001);
    step(); idle_in();
    cdb_valid = 4'b0100; cdb_tag = 16'h0300; cdb_value = '0; cdb_value[32 +: 16] = 16'h1234;
    step(); chk("wk_not_yet", 64'(out_valid), 0);
    cdb_valid = '0; step();
    chk("wk_valid", 64'(out_valid), 1);
    chk("wk_a", 64'(out_a), 16'h1234);
    step();
    dispatch(4'd3, 1'b0, 16'h0, 4'd3, 1'b1, 16'h0002);
    cdb_valid = 4'b0001; cdb_tag = 16'h0003; cdb_value[15:0] = 16'hBEEF;
    step(); idle_in(); step();
    chk("byp_valid", 64'(out_valid), 1);
    chk("byp_a", 64'(out_a), 16'hBEEF);
    step();

    // fill, drop while full, broadcast: issue in age order
    for (int r = 1; r <= 4; r++) begin
      dispatch(4'(r), 1'b0, 16'h0, 4'd9, 1'b1, 16'(r));
      step();
    end
    chk("fill_full", 64'(full), 1);
    dispatch(4'd5, 1'b1, 16'h55, 4'd0, 1'b1, 16'h56);
    step(); idle_in();
    chk("drop_count", 64'(count), 4);
    cdb_valid = 4'b0010; cdb_tag = 16'h0090; cdb_value[31:16] = 16'h0909;
    step(); cdb_valid = '0;
    for (int r = 1; r <= 4; r++) begin
      step();
      chk("order_rob", 64'(out_rob_idx), 64'(r));
    end
    step();
    chk("order_drained", 64'(out_valid), 0);

    // backpressure
    out_ready = 1'b0;
    dispatch(4'd6, 1'b1, 16'h66, 4'd0, 1'b1, 16'h67); step();
    dispatch(4'd7, 1'b1, 16'h77, 4'd0, 1'b1, 16'h78); step(); idle_in();
    chk("bp_first", 64'(out_rob_idx), 6);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold_rob", 64'(out_rob_idx), 6);
      chk("bp_hold_a", 64'(out_a), 16'h66);
      chk("bp_hold_count", 64'(count), 1);
    end
    out_ready = 1'b1; step();
    chk("bp_next", 64'(out_rob_idx), 7);
    step();
    chk("bp_empty", 64'(out_valid), 0);

    // flush beats dispatch
    out_ready = 1'b0;
    dispatch(4'd8, 1'b0, 16'h0, 4'd12, 1'b1, 16'h1); step();
    dispatch(4'd9, 1'b0, 16'h0, 4'd12, 1'b1, 16'h2); step();
    chk("fl_pre_count", 64'(count), 2);
    flush = 1'b1; dispatch(4'd10, 1'b1, 16'hA, 4'd0, 1'b1, 16'hB);
    step(); idle_in();
    chk("fl_count", 64'(count), 0);
    chk("fl_out_valid", 64'(out_valid), 0);
    step();
    chk("fl_not_written", 64'(out_valid), 0);

    // async reset mid-run with 3 waiting entries and a held issue
    dispatch(4'd1, 1'b1, 16'h11, 4'd0, 1'b1, 16'h12); step();
    for (int r = 2; r <= 4; r++) begin
      dispatch(4'(r), 1'b0, 16'h0, 4'd13, 1'b1, 16'h0); step();
    end
    idle_in();
    chk("mr_pre_count", 64'(count), 3);
    rst_n = 1'b0; #1;
    chk("mr_count", 64'(count), 0);
    chk("mr_out_valid", 64'(out_valid), 0);
    chk("mr_full", 64'(full), 0);
    step(); rst_n = 1'b1; out_ready = 1'b1; step();

    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 9) < 6);
      in_rob_idx = 4'($urandom); in_opcode = 4'($urandom); in_imm = 8'($urandom);
      in_a_valid = 1'($urandom); in_a_value = 16'($urandom); in_a_owner = 4'($urandom_range(0, 7));
      in_b_valid = 1'($urandom); in_b_value = 16'($urandom); in_b_owner = 4'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) begin
        cdb_valid[k] = ($urandom_range(0, 9) < 3);
        cdb_tag[k*4 +: 4] = 4'($urandom_range(0, 7));
        cdb_value[k*16 +: 16] = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_in(); out_ready = 1'b1;
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
